// File: rtl/sc_mux5_sequencer_pkg.sv
// Shared state codes and display-mux select constants for the game-flow sequencer.
// The mux instantiation reuses the SEL_* constants so the select codes stay in one place.
package sc_mux5_sequencer_pkg;

  typedef enum logic [2:0] {
    COMIENZO = 3'd0,
    PLAY     = 3'd1,
    TRANSI   = 3'd2,
    PIERDO   = 3'd3
  } stateT;

  localparam logic [1:0] SEL_COMIENZO = 2'd0;
  localparam logic [1:0] SEL_RANDOM   = 2'd1;
  localparam logic [1:0] SEL_TRANSI   = 2'd2;
  localparam logic [1:0] SEL_PIERDO   = 2'd3;

  function automatic logic isDwellState(input stateT s);
    return (s == TRANSI) || (s == PIERDO);
  endfunction

endpackage

// File: rtl/sc_mux5_sequencer_dwell_counter.sv
// Tick-enabled dwell counter with clear; done fires on the tick seen while at terminal.
// The count saturates at terminal, so it never wraps however many ticks follow.
module sc_dwell_counter #(
  parameter int DWELLWIDTH = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_InHigh,
  input  logic                  clear,
  input  logic                  tick,
  input  logic [DWELLWIDTH-1:0] terminal,
  output logic                  done
);

  logic [DWELLWIDTH-1:0] dwellQ;

  always_ff @(posedge CLOCK_50) begin
    if (RESET_InHigh || clear) begin
      dwellQ <= '0;
    end else if (tick && (dwellQ != terminal)) begin
      dwellQ <= dwellQ + DWELLWIDTH'(1);
    end
  end

  assign done = tick && !clear && (dwellQ == terminal);

endmodule

// File: rtl/sc_mux5_sequencer.sv
// Game-flow FSM: drives the 4-way display mux select, the display-register load
// strobe and the level counter; dwell timing is delegated to sc_dwell_counter.
module sc_mux5_sequencer
  import sc_mux5_sequencer_pkg::*;
#(
  parameter int SELECTWIDTH  = 4,
  parameter int LEVELWIDTH   = 4,
  parameter int LEVEL_MAX    = 7,
  parameter int DWELLWIDTH   = 8,
  parameter int TRANSI_TICKS = 8,
  parameter int PIERDO_TICKS = 16
) (
  input  logic                   SC_MUX5SEQ_CLOCK_50,
  input  logic                   SC_MUX5SEQ_RESET_InHigh,
  input  logic                   SC_MUX5SEQ_start_InHigh,
  input  logic                   SC_MUX5SEQ_tick_InHigh,
  input  logic                   SC_MUX5SEQ_crash_InHigh,
  input  logic                   SC_MUX5SEQ_levelDone_InHigh,
  output logic [SELECTWIDTH-1:0] SC_MUX5SEQ_select_OutBUS,
  output logic                   SC_MUX5SEQ_load_OutHigh,
  output logic [LEVELWIDTH-1:0]  SC_MUX5SEQ_level_OutBUS,
  output logic [2:0]             SC_MUX5SEQ_state_OutBUS
);

  stateT                 stateQ;
  logic [SELECTWIDTH-1:0] selectQ;
  logic                  loadQ;
  logic [LEVELWIDTH-1:0] levelQ;

  logic                  dwellClear;
  logic                  dwellDone;
  logic [DWELLWIDTH-1:0] dwellTerminal;

  // Counter is held clear outside the dwell screens, so every entry starts at zero.
  assign dwellClear    = !isDwellState(stateQ);
  assign dwellTerminal = (stateQ == TRANSI) ? DWELLWIDTH'(TRANSI_TICKS - 1)
                                            : DWELLWIDTH'(PIERDO_TICKS - 1);

  sc_dwell_counter #(
    .DWELLWIDTH(DWELLWIDTH)
  ) uDwell (
    .CLOCK_50    (SC_MUX5SEQ_CLOCK_50),
    .RESET_InHigh(SC_MUX5SEQ_RESET_InHigh),
    .clear       (dwellClear),
    .tick        (SC_MUX5SEQ_tick_InHigh),
    .terminal    (dwellTerminal),
    .done        (dwellDone)
  );

  always_ff @(posedge SC_MUX5SEQ_CLOCK_50) begin
    if (SC_MUX5SEQ_RESET_InHigh) begin
      stateQ  <= COMIENZO;
      selectQ <= SELECTWIDTH'(SEL_COMIENZO);
      loadQ   <= 1'b0;
      levelQ  <= '0;
    end else begin
      loadQ <= 1'b0;
      case (stateQ)
        COMIENZO: begin
          if (SC_MUX5SEQ_start_InHigh) begin
            stateQ  <= PLAY;
            selectQ <= SELECTWIDTH'(SEL_RANDOM);
            loadQ   <= 1'b1;
            levelQ  <= '0;
          end
        end
        PLAY: begin
          // Crash has priority over levelDone; an entry load absorbs a coincident tick.
          if (SC_MUX5SEQ_crash_InHigh) begin
            stateQ  <= PIERDO;
            selectQ <= SELECTWIDTH'(SEL_PIERDO);
            loadQ   <= 1'b1;
          end else if (SC_MUX5SEQ_levelDone_InHigh) begin
            stateQ  <= TRANSI;
            selectQ <= SELECTWIDTH'(SEL_TRANSI);
            loadQ   <= 1'b1;
          end else if (SC_MUX5SEQ_tick_InHigh) begin
            loadQ <= 1'b1;
          end
        end
        TRANSI: begin
          if (dwellDone) begin
            loadQ <= 1'b1;
            if (levelQ == LEVELWIDTH'(LEVEL_MAX)) begin
              stateQ  <= COMIENZO;
              selectQ <= SELECTWIDTH'(SEL_COMIENZO);
              levelQ  <= '0;
            end else begin
              stateQ  <= PLAY;
              selectQ <= SELECTWIDTH'(SEL_RANDOM);
              levelQ  <= levelQ + LEVELWIDTH'(1);
            end
          end
        end
        PIERDO: begin
          if (dwellDone) begin
            stateQ  <= COMIENZO;
            selectQ <= SELECTWIDTH'(SEL_COMIENZO);
            loadQ   <= 1'b1;
          end
        end
        default: begin
          stateQ  <= COMIENZO;
          selectQ <= SELECTWIDTH'(SEL_COMIENZO);
          loadQ   <= 1'b1;
        end
      endcase
    end
  end

  assign SC_MUX5SEQ_select_OutBUS = selectQ;
  assign SC_MUX5SEQ_load_OutHigh  = loadQ;
  assign SC_MUX5SEQ_level_OutBUS  = levelQ;
  assign SC_MUX5SEQ_state_OutBUS  = stateQ;

endmodule

// File: doc/sc_mux5_sequencer.md
Name: sc_mux5_sequencer

Overview:
Game-flow controller that drives the select bus of the 4-way display pattern mux (0=COMIENZO, 1=RANDOM/play field, 2=TRANSI, 3=PIERDO).
- Issues the load strobe to the downstream display register.
- Tracks the current level.
- Times the transition and lose screens in frame ticks.
- Sits between the debounced button/game-logic event pulses and the mux/register datapath.

Parameters:
- SELECTWIDTH, 4, width of select bus; must match the mux select width.
- LEVELWIDTH, 4, width of level counter.
- LEVEL_MAX, 7, last level; completing it returns to COMIENZO.
- DWELLWIDTH, 8, width of dwell (tick) counter.
- TRANSI_TICKS, 8, ticks the TRANSI screen is held (1..2^DWELLWIDTH-1).
- PIERDO_TICKS, 16, ticks the PIERDO screen is held (1..2^DWELLWIDTH-1).

Ports:
- SC_MUX5SEQ_CLOCK_50  in  1  system clock; single clock domain.
- SC_MUX5SEQ_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_MUX5SEQ_start_InHigh  in  1  one-cycle start pulse from debouncer.
- SC_MUX5SEQ_tick_InHigh  in  1  one-cycle frame-tick enable.
- SC_MUX5SEQ_crash_InHigh  in  1  one-cycle lose event from game logic.
- SC_MUX5SEQ_levelDone_InHigh  in  1  one-cycle level-complete event.
- SC_MUX5SEQ_select_OutBUS  out  SELECTWIDTH  mux select, registered.
- SC_MUX5SEQ_load_OutHigh  out  1  one-cycle display-register load strobe, registered.
- SC_MUX5SEQ_level_OutBUS  out  LEVELWIDTH  current level, registered.
- SC_MUX5SEQ_state_OutBUS  out  3  encoded FSM state (debug/LEDs).

Behaviour:
- Reset (sampled on clock edge while RESET_InHigh=1, overrides all inputs):
  - state=COMIENZO, select=0, load=0, level=0, dwell=0.
  - A reset arriving mid-TRANSI or mid-PIERDO aborts the dwell immediately.
- Output timing:
  - All outputs are registered.
  - An event sampled in cycle N updates state/select in cycle N+1.
  - load=1 in cycle N+1 exactly when select first shows its new value (on every state entry).
  - load=1 for one cycle following each tick accepted in PLAY.
  - load=0 otherwise.
- State encoding: COMIENZO=0, PLAY=1, TRANSI=2, PIERDO=3. Select equals the state code, zero-extended to SELECTWIDTH.
- COMIENZO (select=0):
  - start -> PLAY; level cleared to 0.
  - tick, crash and levelDone are ignored.
- PLAY (select=1):
  - tick -> load pulse, state unchanged.
  - crash -> PIERDO.
  - levelDone -> TRANSI.
  - crash and levelDone in the same cycle: crash wins (PIERDO).
  - Any event together with tick: the event transition is taken, and a single load is issued for the entry.
  - start is ignored.
- TRANSI (select=2):
  - dwell cleared on entry, increments on each tick.
  - On the tick where dwell reaches TRANSI_TICKS-1, exit:
    - level==LEVEL_MAX -> COMIENZO, level=0.
    - otherwise level=level+1 -> PLAY.
  - start, crash and levelDone are ignored.
- PIERDO (select=3):
  - dwell cleared on entry, increments on each tick.
  - On the tick where dwell reaches PIERDO_TICKS-1, go to COMIENZO. Level is held until the next start.
  - start, crash and levelDone are ignored.
- Arithmetic:
  - Level never exceeds LEVEL_MAX and never wraps.
  - dwell never wraps; it is compared with == and saturates at its terminal value.
- Illegal state codes (e.g. from an upset) decode to COMIENZO on the next clock, with load=1.

Decomposition:
- Shared package (or include file of localparams):
  - state codes COMIENZO/PLAY/TRANSI/PIERDO.
  - select constants 0..3, reused by the mux instantiation.
- One natural sub-module: sc_dwell_counter.
  - Function: tick-enabled counter with clear and a terminal-count compare input.
  - Used by both TRANSI and PIERDO.
  - Ports: CLOCK_50, RESET_InHigh, clear, tick, terminal, done.
- The FSM, level counter and load logic stay in sc_mux5_sequencer.

Test Plan:
1. Reset held 3 cycles, then released with no stimulus -> select=0, load=0, level=0, state=0 indefinitely; tick pulses cause no change.
2. start pulse at cycle N -> cycle N+1: select=1, load=1; cycle N+2: load=0. Then 3 ticks -> exactly 3 single-cycle load pulses, each one cycle after its tick.
3. In PLAY, levelDone -> select=2 with load. 7 ticks -> still select=2. 8th tick -> select=1, level=1, load=1. Repeat until level=7; the next TRANSI completion -> select=0, level=0.
4. In PLAY, crash and levelDone asserted in the same cycle -> select=3, level unchanged. 15 ticks -> select=3. 16th tick -> select=0. A start given during PIERDO is ignored.
5. Reset asserted mid-PIERDO with dwell=10 -> next cycle select=0, level=0, load=0. A subsequent start reaches PLAY normally.
6. Force illegal state code 5 via the bench -> next cycle state=0, select=0, load=1.
